// File: rtl/branch_predict_resolve.sv
// Branch unit: predicts direction from a PC-indexed table of 2-bit saturating
// counters, resolves conditional branches and jumps, flags mispredictions,
// and keeps saturating branch/mispredict statistics. A clear request walks
// the table back to weak-not-taken one entry per cycle.
module branch_predict_resolve #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_out_valid,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             res_jump,
    input  logic [2:0]       res_func3,
    input  logic [XLEN-1:0]  res_a,
    input  logic [XLEN-1:0]  res_b,
    input  logic             res_pred_taken,
    output logic             res_out_valid,
    output logic             res_taken,
    output logic             mispredict,
    output logic             res_illegal,
    input  logic             clear,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] ptr;
    logic [1:0]          counter_table [DEPTH];

    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] res_idx;
    logic                cond_taken;
    logic                actual_taken;
    logic                is_illegal;
    logic                table_update;
    logic                is_mispredict;
    logic                unused_pc_bits;

    // Instructions are word aligned, so the two low PC bits never select an entry.
    assign pred_idx = pred_pc[IDX_BITS+1:2];
    assign res_idx  = res_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_BITS+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_BITS+2], res_pc[1:0]};

    // Evaluate the branch condition; jumps override it and are never illegal.
    always_comb begin
        cond_taken = 1'b0;
        is_illegal = 1'b0;
        case (res_func3)
            3'b000:  cond_taken = (res_a == res_b);
            3'b001:  cond_taken = (res_a != res_b);
            3'b100:  cond_taken = ($signed(res_a) < $signed(res_b));
            3'b101:  cond_taken = ($signed(res_a) >= $signed(res_b));
            3'b110:  cond_taken = (res_a < res_b);
            3'b111:  cond_taken = (res_a >= res_b);
            default: is_illegal = 1'b1;
        endcase
        if (res_jump) begin
            actual_taken = 1'b1;
            is_illegal   = 1'b0;
        end else begin
            actual_taken = cond_taken;
        end
    end

    assign table_update  = res_valid && !res_jump && !is_illegal;
    assign is_mispredict = (actual_taken != res_pred_taken);

    // Counter table and clear walk share one block so each entry has a single writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                counter_table[i] <= 2'b01;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (table_update) begin
                        if (actual_taken) begin
                            if (counter_table[res_idx] != 2'b11) begin
                                counter_table[res_idx] <= counter_table[res_idx] + 2'd1;
                            end
                        end else begin
                            if (counter_table[res_idx] != 2'b00) begin
                                counter_table[res_idx] <= counter_table[res_idx] - 2'd1;
                            end
                        end
                    end
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    counter_table[ptr] <= 2'b01;
                    if (ptr == IDX_BITS'(DEPTH - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + IDX_BITS'(1);
                    end
                end
            endcase
        end
    end

    // Prediction reads the pre-update counter; a walk in progress forces not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
        end else begin
            pred_out_valid <= pred_valid;
            pred_taken     <= pred_valid && !busy && counter_table[pred_idx][1];
        end
    end

    // Register the resolution outcome, held low when nothing is resolving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_out_valid <= 1'b0;
            res_taken     <= 1'b0;
            mispredict    <= 1'b0;
            res_illegal   <= 1'b0;
        end else begin
            res_out_valid <= res_valid;
            res_taken     <= res_valid && actual_taken;
            mispredict    <= res_valid && is_mispredict;
            res_illegal   <= res_valid && is_illegal;
        end
    end

    // Statistics count every resolution and stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (res_valid && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (res_valid && is_mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
